// File: rtl/opcode_decode_pipe.sv
// opcode_decode_pipe
//   Registered MIPS32 instruction decoder with a valid/ready handshake and a
//   2-entry skid buffer (main + skid register). Each accepted instruction is
//   decoded into ALU controls (I, S, Cin), one-hot register selects and a
//   sign-extended immediate, and is presented one cycle after acceptance.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   ibus       instruction word
//   in_valid   ibus holds a valid instruction
//   in_ready   decoder can accept (registered, independent of out_ready)
//   flush      synchronous discard of every buffered decode
//   out_valid  decoded bundle valid
//   out_ready  downstream accepts the bundle
//   I, S, Cin  ALU immediate-select, function select, carry-in
//   Aselect    one-hot rs
//   Bselect    one-hot rt, all-zero for immediate-operand instructions
//   Dselect    one-hot destination (bit 0 for illegal instructions)
//   imm        ibus[15:0] sign-extended to DATA_W
//   illegal    opcode/funct not in the decode table
module opcode_decode_pipe #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int RSEL_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ibus,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              I,
    output logic [2:0]        S,
    output logic              Cin,
    output logic [NREG-1:0]   Aselect,
    output logic [NREG-1:0]   Bselect,
    output logic [NREG-1:0]   Dselect,
    output logic [DATA_W-1:0] imm,
    output logic              illegal
);

    typedef struct packed {
        logic              i;
        logic [2:0]        s;
        logic              cin;
        logic [NREG-1:0]   asel;
        logic [NREG-1:0]   bsel;
        logic [NREG-1:0]   dsel;
        logic [DATA_W-1:0] imm;
        logic              illegal;
    } bundle_t;

    localparam bundle_t RESET_BUNDLE = '{
        i:       1'b0,
        s:       3'b111,
        cin:     1'b0,
        asel:    '0,
        bsel:    '0,
        dsel:    NREG'(1),
        imm:     '0,
        illegal: 1'b0
    };

    function automatic logic [NREG-1:0] one_hot(input logic [RSEL_W-1:0] idx);
        one_hot      = '0;
        one_hot[idx] = 1'b1;
    endfunction

    // Instruction fields; only the low RSEL_W bits of each register field
    // are used, so smaller register files simply ignore the upper bits.
    logic [5:0]        op;
    logic [5:0]        fn;
    logic [RSEL_W-1:0] rs;
    logic [RSEL_W-1:0] rt;
    logic [RSEL_W-1:0] rd;

    assign op = ibus[31:26];
    assign fn = ibus[5:0];
    assign rs = ibus[21 +: RSEL_W];
    assign rt = ibus[16 +: RSEL_W];
    assign rd = ibus[11 +: RSEL_W];

    // ------------------------------------------------------------------
    // Combinational decode of the instruction currently on ibus
    // ------------------------------------------------------------------
    bundle_t dec;

    always_comb begin
        // NOTE: every field gets a default before the case so no path
        // leaves a field unassigned, which would infer a latch.
        dec         = '0;
        dec.s       = 3'b111;
        dec.illegal = 1'b0;
        case (op)
            6'b000011: begin dec.i = 1'b1; dec.s = 3'b010; end
            6'b000010: begin dec.i = 1'b1; dec.s = 3'b011; dec.cin = 1'b1; end
            6'b000001: begin dec.i = 1'b1; dec.s = 3'b000; end
            6'b001111: begin dec.i = 1'b1; dec.s = 3'b110; end
            6'b001100: begin dec.i = 1'b1; dec.s = 3'b100; end
            6'b000000: begin
                case (fn)
                    6'b000011: dec.s = 3'b010;
                    6'b000010: begin dec.s = 3'b011; dec.cin = 1'b1; end
                    6'b000001: dec.s = 3'b000;
                    6'b000111: dec.s = 3'b110;
                    6'b000100: dec.s = 3'b100;
                    default:   dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase

        dec.asel = one_hot(rs);
        // Register operand B only when the ALU is not taking the immediate.
        dec.bsel = dec.i ? '0 : one_hot(rt);
        // Illegal instructions write r0 so the result is discarded.
        if (dec.illegal) begin
            dec.dsel = NREG'(1);
        end else if (dec.i) begin
            dec.dsel = one_hot(rt);
        end else begin
            dec.dsel = one_hot(rd);
        end
        dec.imm = {{(DATA_W-16){ibus[15]}}, ibus[15:0]};
    end

    // ------------------------------------------------------------------
    // Skid buffer control
    // ------------------------------------------------------------------
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    main_valid_q, main_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    in_ready_q, in_ready_d;
    logic    accept;
    logic    drain;

    assign accept = in_valid & in_ready_q;
    assign drain  = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            // Flush beats both accept and drain; payloads keep their last
            // value since they are don't-care while invalid.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            if (skid_valid_q) begin
                // in_ready is low whenever skid is full, so no accept here.
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = dec;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (!main_valid_q) begin
            if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end
        end else if (accept) begin
            // Main is stalled: park the new bundle behind it.
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end

        // Ready is a function of next-state occupancy only, so it never
        // depends combinationally on out_ready.
        in_ready_d = ~skid_valid_d;
    end

    // NOTE: clocked blocks use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q       <= RESET_BUNDLE;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // NOTE: the skid payload has no reset; skid_valid_q qualifies it, so
    // its power-up contents are never observed.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign I         = main_q.i;
    assign S         = main_q.s;
    assign Cin       = main_q.cin;
    assign Aselect   = main_q.asel;
    assign Bselect   = main_q.bsel;
    assign Dselect   = main_q.dsel;
    assign imm       = main_q.imm;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_opcode_decode_pipe.sv
// tb_opcode_decode_pipe
//   Self-checking bench for opcode_decode_pipe. A table of instruction
//   vectors with hand-derived decode results feeds a scoreboard queue:
//   a record is pushed when an instruction is accepted and compared against
//   the DUT outputs every cycle it sits at the head (so stall stability is
//   covered), and popped when downstream takes it. A second instance with
//   NREG=16, DATA_W=64 covers the narrow-select / wide-immediate corner.
module tb_opcode_decode_pipe;

    typedef struct {
        logic [31:0] ibus;
        logic        i;
        logic [2:0]  s;
        logic        cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    localparam int NV = 13;

    logic        clk = 1'b0;
    bit          clk_en = 1'b0;
    logic        reset;
    logic [31:0] ibus;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        i_o;
    logic [2:0]  s_o;
    logic        cin_o;
    logic [31:0] asel_o;
    logic [31:0] bsel_o;
    logic [31:0] dsel_o;
    logic [31:0] imm_o;
    logic        ill_o;

    // Second instance: 16 registers, 64-bit immediate.
    logic [31:0] ibus2;
    logic        in_valid2;
    logic        in_ready2;
    logic        flush2;
    logic        out_valid2;
    logic        out_ready2;
    logic        i2;
    logic [2:0]  s2;
    logic        cin2;
    logic [15:0] asel2;
    logic [15:0] bsel2;
    logic [15:0] dsel2;
    logic [63:0] imm2;
    logic        ill2;

    int   n_checks = 0;
    int   n_err    = 0;
    vec_t vecs[NV];
    vec_t cur_vec;
    vec_t sb[$];

    always #5 if (clk_en) clk = ~clk;

    opcode_decode_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .ibus      (ibus),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .I         (i_o),
        .S         (s_o),
        .Cin       (cin_o),
        .Aselect   (asel_o),
        .Bselect   (bsel_o),
        .Dselect   (dsel_o),
        .imm       (imm_o),
        .illegal   (ill_o)
    );

    opcode_decode_pipe #(.DATA_W(64), .NREG(16), .RSEL_W(4)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .ibus      (ibus2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .flush     (flush2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .I         (i2),
        .S         (s2),
        .Cin       (cin2),
        .Aselect   (asel2),
        .Bselect   (bsel2),
        .Dselect   (dsel2),
        .imm       (imm2),
        .illegal   (ill2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    task automatic present(input vec_t v);
        cur_vec = v;
        ibus    = v.ibus;
    endtask

    task automatic compare_front(input vec_t v);
        check("I",       64'(i_o),    64'(v.i));
        check("S",       64'(s_o),    64'(v.s));
        check("Cin",     64'(cin_o),  64'(v.cin));
        check("Aselect", 64'(asel_o), 64'(v.a));
        check("Bselect", 64'(bsel_o), 64'(v.b));
        check("Dselect", 64'(dsel_o), 64'(v.d));
        check("imm",     64'(imm_o),  64'(v.imm));
        check("illegal", 64'(ill_o),  64'(v.ill));
    endtask

    // One clock cycle. Inputs were set just after the previous rising edge;
    // outputs and the handshake are evaluated on the falling edge, then the
    // scoreboard advances according to what the rising edge will do.
    task automatic step(output bit acc);
        bit drn;
        @(negedge clk);
        check("in_ready",  64'(in_ready),  64'(sb.size() < 2));
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) compare_front(sb[0]);
        acc = in_valid && (sb.size() < 2) && !flush;
        drn = out_ready && (sb.size() != 0) && !flush;
        if (flush) begin
            sb.delete();
        end else begin
            if (drn) void'(sb.pop_front());
            if (acc) sb.push_back(cur_vec);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int k;

        //           ibus                                    I     S       Cin   Aselect        Bselect        Dselect        imm            illegal
        vecs[0]  = '{32'h0C22_FFFC,                          1'b1, 3'b010, 1'b0, 32'h0000_0002, 32'h0000_0000, 32'h0000_0004, 32'hFFFF_FFFC, 1'b0};
        vecs[1]  = '{32'h0043_2002,                          1'b0, 3'b011, 1'b1, 32'h0000_0004, 32'h0000_0008, 32'h0000_0010, 32'h0000_2002, 1'b0};
        vecs[2]  = '{32'hFC00_0000,                          1'b0, 3'b111, 1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[3]  = '{itype(6'b000010, 5, 7, 16'h0010),       1'b1, 3'b011, 1'b1, 32'h0000_0020, 32'h0000_0000, 32'h0000_0080, 32'h0000_0010, 1'b0};
        vecs[4]  = '{itype(6'b000001, 31, 0, 16'h7FFF),      1'b1, 3'b000, 1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_7FFF, 1'b0};
        vecs[5]  = '{itype(6'b001111, 0, 31, 16'h8000),      1'b1, 3'b110, 1'b0, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_8000, 1'b0};
        vecs[6]  = '{itype(6'b001100, 10, 20, 16'h1234),     1'b1, 3'b100, 1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0010_0000, 32'h0000_1234, 1'b0};
        vecs[7]  = '{rtype(1, 2, 3, 6'b000011),              1'b0, 3'b010, 1'b0, 32'h0000_0002, 32'h0000_0004, 32'h0000_0008, 32'h0000_1803, 1'b0};
        vecs[8]  = '{rtype(31, 30, 29, 6'b000001),           1'b0, 3'b000, 1'b0, 32'h8000_0000, 32'h4000_0000, 32'h2000_0000, 32'hFFFF_E801, 1'b0};
        vecs[9]  = '{rtype(0, 0, 1, 6'b000111),              1'b0, 3'b110, 1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 32'h0000_0807, 1'b0};
        vecs[10] = '{rtype(6, 9, 12, 6'b000100),             1'b0, 3'b100, 1'b0, 32'h0000_0040, 32'h0000_0200, 32'h0000_1000, 32'h0000_6004, 1'b0};
        vecs[11] = '{rtype(3, 4, 5, 6'b100000),              1'b0, 3'b111, 1'b0, 32'h0000_0008, 32'h0000_0010, 32'h0000_0001, 32'h0000_2820, 1'b1};
        vecs[12] = '{itype(6'b001000, 2, 3, 16'hFFFF),       1'b0, 3'b111, 1'b0, 32'h0000_0004, 32'h0000_0008, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};

        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        ibus2      = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        flush2     = 1'b0;
        present(vecs[0]);

        // Reset with the clock stopped.
        #3;
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_S",         64'(s_o),       64'(3'b111));
        check("rst_Dselect",   64'(dsel_o),    64'(32'h1));
        check("rst_I",         64'(i_o),       64'(0));
        check("rst_Aselect",   64'(asel_o),    64'(0));
        check("rst_imm",       64'(imm_o),     64'(0));
        check("rst2_Dselect",  64'(dsel2),     64'(16'h1));

        clk_en = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Narrow-select / wide-immediate instance.
        ibus2      = itype(6'b000011, 5'b10011, 5'b10101, 16'h8000);
        in_valid2  = 1'b1;
        out_ready2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        @(negedge clk);
        check("p2_out_valid", 64'(out_valid2), 64'(1));
        check("p2_I",         64'(i2),         64'(1));
        check("p2_S",         64'(s2),         64'(3'b010));
        check("p2_Aselect",   64'(asel2),      64'(16'h0008));
        check("p2_Bselect",   64'(bsel2),      64'(16'h0000));
        check("p2_Dselect",   64'(dsel2),      64'(16'h0020));
        check("p2_imm",       imm2,            64'hFFFF_FFFF_FFFF_8000);
        @(posedge clk);
        #1;

        // Every table entry back to back with downstream always ready:
        // exercises 1-cycle latency and simultaneous drain + accept.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int n = 0; n < NV; n++) begin
            present(vecs[n]);
            step(acc);
        end
        in_valid = 1'b0;
        step(acc);
        step(acc);

        // Stream of three with downstream stalled, then released.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        k = 3;
        for (int c = 0; c < 4; c++) begin
            present(vecs[k]);
            step(acc);
            if (acc) k++;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6 && k < 6; c++) begin
            present(vecs[k]);
            step(acc);
            if (acc) k++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) step(acc);

        // Full buffer flushed while a new instruction and out_ready are up.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        present(vecs[7]);
        step(acc);
        present(vecs[8]);
        step(acc);
        present(vecs[9]);
        flush     = 1'b1;
        out_ready = 1'b1;
        step(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) step(acc);
        in_valid = 1'b1;
        present(vecs[10]);
        step(acc);
        in_valid = 1'b0;
        step(acc);
        step(acc);

        // Flush beats an accept while in_ready is high.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        present(vecs[4]);
        step(acc);
        present(vecs[5]);
        flush = 1'b1;
        step(acc);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) step(acc);

        // Reset mid-operation acts before any further clock edge.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        present(vecs[6]);
        step(acc);
        present(vecs[1]);
        step(acc);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready",  64'(in_ready),  64'(1));
        check("midrst_Dselect",   64'(dsel_o),    64'(32'h1));
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic with occasional flushes.
        for (int c = 0; c < 300; c++) begin
            present(vecs[$urandom_range(0, NV - 1)]);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            step(acc);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step(acc);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/opcode_decode_pipe.md
Name: opcode_decode_pipe

Overview:
Registered, parametrised instruction decoder for the 3-stage MIPS32 datapath. It sits between the instruction fetch register and the register-file/ALU stage. Each instruction fetched on ibus is decoded into the ALU controls (I, S, Cin), the one-hot register selects and a sign-extended immediate. Unlike the combinational decoder it replaces, it has a valid/ready handshake, a 2-entry skid buffer (registered in_ready), a flush input and an illegal-instruction flag.

Parameters:
DATA_W, 32, width of the sign-extended immediate output
NREG, 32, number of architectural registers; width of each one-hot select (must be a power of 2, at most 32)
RSEL_W, 5, register-field width used for indexing (log2 NREG); upper field bits are ignored when NREG < 32

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
ibus  in  32  instruction word
in_valid  in  1  ibus holds a valid instruction
in_ready  out  1  decoder can accept; registered
flush  in  1  discard all buffered and in-flight decodes (branch/exception)
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts bundle
I  out  1  1 = immediate operand selected for ALU B
S  out  3  ALU function select
Cin  out  1  ALU carry-in
Aselect  out  NREG  one-hot, rs
Bselect  out  NREG  one-hot, rt (all-zero when I=1)
Dselect  out  NREG  one-hot destination
imm  out  DATA_W  ibus[15:0] sign-extended to DATA_W
illegal  out  1  opcode/funct not in decode table

Behaviour:
- Reset (async, reset=1): in_ready=1, out_valid=0, both buffer entries empty. Bundle outputs are 0, except S=3'b111 and Dselect=one-hot bit 0.
- Decode table, op=ibus[31:26], fn=ibus[5:0]:
  - op 000011 -> I1 S010 C0
  - op 000010 -> I1 S011 C1
  - op 000001 -> I1 S000 C0
  - op 001111 -> I1 S110 C0
  - op 001100 -> I1 S100 C0
  - op 000000 with fn 000011 -> I0 S010 C0; fn 000010 -> I0 S011 C1; fn 000001 -> I0 S000 C0; fn 000111 -> I0 S110 C0; fn 000100 -> I0 S100 C0
  - anything else -> I0 S111 C0, illegal=1, Dselect forced to bit 0 (write to r0 is discarded)
- Register selects:
  - Aselect = 1<<rs[RSEL_W-1:0].
  - R-type: Bselect = 1<<rt, Dselect = 1<<rd (ibus[15:11]).
  - I-type: Bselect = 0, Dselect = 1<<rt (ibus[20:16]).
- Immediate: imm = {{(DATA_W-16){ibus[15]}}, ibus[15:0]}; computed for every instruction.
- Latency: 1 cycle. An instruction accepted at edge N (in_valid & in_ready) presents its bundle with out_valid=1 after edge N when the buffer was empty.
- Handshake:
  - A transfer occurs on any edge where valid & ready.
  - The bundle is held stable while out_valid & !out_ready.
  - in_ready never depends combinationally on out_ready.
- Skid buffer:
  - Main register plus skid register.
  - If the main register holds a bundle that is stalled and a new instruction arrives, the new bundle goes to the skid register and in_ready drops on the next cycle.
  - When main drains, skid moves to main and in_ready returns to 1 on the following cycle.
  - Simultaneous drain and accept with an empty skid: the new bundle goes straight to main and out_valid stays 1.
  - Ordering is strictly FIFO; a full buffer holds 2 bundles with in_ready=0.
- Flush:
  - Synchronous. On an edge with flush=1, both entries are emptied, out_valid=0 and in_ready=1.
  - An instruction presented in the same cycle is dropped (flush has priority over accept).
  - Downstream must ignore out_ready in a flush cycle.
- Reset mid-operation clears all state immediately, regardless of clk.
- out_valid=0: bundle outputs hold their last value and are don't-care.

Test Plan:
- Reset asserted, clock not running -> in_ready=1, out_valid=0, S=111, Dselect=32'h1.
- ibus=32'h0C22_FFFC (op 000011, rs=1, rt=2, imm=-4), out_ready=1 -> one cycle later: I=1, S=010, Cin=0, Aselect=32'h2, Bselect=0, Dselect=32'h4, imm=32'hFFFF_FFFC, illegal=0.
- ibus=32'h0043_2002 (R-type, rs=2, rt=3, rd=4, fn 000010) -> I=0, S=011, Cin=1, Aselect=32'h4, Bselect=32'h8, Dselect=32'h10.
- Stream of 3 instructions with out_ready=0 -> 2 accepted, in_ready=0 from the third cycle; raise out_ready -> bundles emerge in order, one per cycle, and in_ready returns to 1.
- Buffer full, then flush=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed and the concurrent instruction never appear.
- ibus=32'hFC00_0000 (op 111111) -> illegal=1, S=111, I=0, Dselect=32'h1. Also run NREG=16, DATA_W=64: rs=5'b10011 gives Aselect=16'h0008, and imm=16'h8000 extends to 64'hFFFF_FFFF_FFFF_8000.
